seq_0100_frame_tx: RTL
======================

// Module: seq_0100_frame_tx
// PURPOSE
//  Serial frame transmitter: the sending end of the 0100 sequence-detection link.
//  - Accepts parallel words on a valid/ready handshake.
//  - Prefixes each word with the 4-bit marker 0100 and shifts it out MSB-first, one bit per clk.
//  - Output x drives the serial input of a 0100 Moore detector.
// PARAMETERS
//  WIDTH       8     payload bits per word (>=1)
//  IDLE_LEVEL  1'b1  level driven on x when no bit is being sent
// PORTS
//  clk      in   1      single clock, rising edge
//  rst_n    in   1      reset, asynchronous assert, active-low
//  data_in  in   WIDTH  payload word, sampled on accept
//  valid    in   1      data_in is valid
//  ready    out  1      transmitter can accept; accept = valid & ready at a rising clk
//  x        out  1      serial bit stream, registered
//  x_vld    out  1      x carries a marker or payload bit this cycle
//  last     out  1      x carries the payload LSB (final bit of the frame)
//  busy     out  1      frame in progress (state != IDLE)
// BEHAVIOUR
//  - Reset (rst_n=0, immediate, async):
//    - state=IDLE, x=IDLE_LEVEL, x_vld=0, last=0, busy=0.
//    - Shift/count registers cleared; ready=1 once state is IDLE.
//  - States:
//    - IDLE -> PRE on accept.
//    - PRE: 4 cycles, marker bits 0,1,0,0. Then -> DATA.
//    - DATA: WIDTH cycles, data_in[WIDTH-1] down to [0].
//    - On the last DATA cycle -> PRE if accept, else -> IDLE.
//  - ready = (state==IDLE) | (state==DATA & bit_cnt==WIDTH-1). Combinational from state, not from valid.
//  - Latency: the first marker bit is on x in the cycle after the accepting edge.
//  - Frame length is 4+WIDTH cycles of x_vld=1.
//  - Back-to-back frames: an accept in the last DATA cycle gives the next marker bit in the very next cycle (no idle gap).
//  - valid with ready=0: the word is held off. The word in flight is unaffected; nothing is dropped or overwritten.
//  - data_in changes after accept have no effect; the word is latched into the shift register.
//  - IDLE: x=IDLE_LEVEL, x_vld=0.
//  - bit_cnt width = $clog2(WIDTH+4); wraps to 0 on a state change.
//  - last=1 only in the final DATA cycle; busy=0 only in IDLE.
//  - Reset mid-frame: the frame is abandoned and x returns to IDLE_LEVEL at once. After release, a fresh accept starts with the marker.
// CONFIGURATION
//  Macro SEQ_TX_PREAMBLE_EN.
//  - Defined: PRE state present; each frame = marker 0100 + WIDTH payload bits (as above).
//  - Undefined: PRE state compiled out.
//    - Accept -> DATA directly; frame = WIDTH payload bits only.
//    - First payload bit appears the cycle after accept.
// STRUCTURE
//  - Package seq_tx_pkg:
//    - state_t enum {IDLE, PRE, DATA}
//    - localparam MARKER = 4'b0100, MARKER_LEN = 4
//  - Sub-module piso_shift_reg #(W): parallel-load, MSB-first shift register with load/shift enables.
//    - Instantiated once, W = WIDTH+4 when SEQ_TX_PREAMBLE_EN is defined, else WIDTH.
//    - Loaded with {MARKER, data_in} (or data_in) on accept.
//  - FSM, counter and output registers live in the top module.
// TESTING (WIDTH=8, SEQ_TX_PREAMBLE_EN defined unless stated)
//  1. Assert rst_n=0 mid-cycle, no clk edge.
//     -> x=1, x_vld=0, last=0, busy=0 at once; ready=1.
//  2. Single accept of 8'hA5.
//     -> x = 0,1,0,0,1,0,1,0,0,1,0,1 over 12 cycles with x_vld=1.
//     -> last=1 only on the 12th bit; then x=1, x_vld=0, ready=1.
//  3. valid held high with 8'h3C then 8'hFF.
//     -> 24 contiguous x_vld cycles: 0100 00111100 0100 11111111, no gap.
//     -> ready=1 only in IDLE and on each last bit.
//  4. Accept 8'h0F; at bit 6 pull rst_n low for 1 cycle.
//     -> x=1, x_vld=0 immediately.
//     -> New accept of 8'h81 sends 0100 10000001 cleanly.
//  5. Loop x into the 0100 Moore non-overlap detector; send 8'hFF from idle.
//     -> detector y=1 exactly once, the cycle after the 4th marker bit.
//  6. SEQ_TX_PREAMBLE_EN undefined; accept 8'hA5.
//     -> x = 1,0,1,0,0,1,0,1 starting the cycle after accept; 8 x_vld cycles.

Source files
------------

// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared states and marker constants for the 0100 frame transmitter
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] MARKER     = 4'b0100;
  localparam int         MARKER_LEN = 4;

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, MSB-first shift register with load/shift enables
module piso_shift_reg #(
  parameter int   W    = 12,
  parameter logic FILL = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] pdata,
  output logic         sout
);

  logic [W-1:0] sr;
  logic [W-1:0] shifted;

  // Shifting in FILL means the register drains to the idle level on its own,
  // so sout can drive the line directly between frames.
  always_comb begin
    shifted = (sr << 1) | W'(FILL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= {W{FILL}};
    end else if (load) begin
      sr <= pdata;
    end else if (shift) begin
      sr <= shifted;
    end
  end

  assign sout = sr[W-1];

endmodule

// File: rtl/seq_0100_frame_tx.sv
// rtl/seq_0100_frame_tx.sv - serial frame transmitter feeding a 0100 detector
// Optional marker prefix enabled by macro SEQ_TX_PREAMBLE_EN.
module seq_0100_frame_tx
  import seq_tx_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid,
  output logic             ready,
  output logic             x,
  output logic             x_vld,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + MARKER_LEN);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

`ifdef SEQ_TX_PREAMBLE_EN
  localparam int            SW       = WIDTH + MARKER_LEN;
  localparam state_t        FIRST    = PRE;
  localparam logic [CW-1:0] PRE_LAST = CW'(MARKER_LEN - 1);
`else
  localparam int            SW       = WIDTH;
  localparam state_t        FIRST    = DATA;
`endif

  state_t        state, state_d;
  logic [CW-1:0] bit_cnt, bit_cnt_d;
  logic          accept;
  logic [SW-1:0] frame_word;

`ifdef SEQ_TX_PREAMBLE_EN
  assign frame_word = {MARKER, data_in};
`else
  assign frame_word = data_in;
`endif

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt + CNT_ONE;
    ready     = 1'b0;
    case (state)
      IDLE: begin
        ready     = 1'b1;
        bit_cnt_d = '0;
        if (valid) state_d = FIRST;
      end
`ifdef SEQ_TX_PREAMBLE_EN
      PRE: begin
        if (bit_cnt == PRE_LAST) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
`endif
      DATA: begin
        // Final payload bit: take the next word here to avoid an idle gap.
        if (bit_cnt == DATA_LAST) begin
          ready     = 1'b1;
          bit_cnt_d = '0;
          state_d   = valid ? FIRST : IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
    end else begin
      state   <= state_d;
      bit_cnt <= bit_cnt_d;
    end
  end

  assign accept = valid & ready;

  piso_shift_reg #(
    .W    (SW),
    .FILL (IDLE_LEVEL)
  ) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .shift ((state != IDLE) & ~accept),
    .pdata (frame_word),
    .sout  (x)
  );

  assign busy  = (state != IDLE);
  assign x_vld = busy;
  assign last  = (state == DATA) && (bit_cnt == DATA_LAST);

endmodule
